// File: rtl/common_pkg.sv
// Shared NoC switch constants and small helpers used across the t_switch blocks.
package common_pkg;

    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;

    // Isolates the lowest set bit; callers truncate the result back to their width.
    function automatic logic [31:0] onehot_lsb(input logic [31:0] x);
        return x & (~x + 32'd1);
    endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer, with wrap.
module noc_rr_arb #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_winIdx;
    logic          w_found;

    always_comb begin : scan
        int j;
        j        = 0;
        gnt      = '0;
        w_winIdx = '0;
        w_found  = 1'b0;
        for (int o = 0; o < N; o++) begin
            j = int'(r_ptr) + o;
            if (j >= N) j = j - N;
            if (!w_found && req[j]) begin
                w_found  = 1'b1;
                gnt[j]   = 1'b1;
                w_winIdx = PW'(j);
            end
        end
    end

    // The pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (int'(w_winIdx) == N - 1) ? '0 : w_winIdx + PW'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/t_switch_out_sched.sv
// Egress scheduler for one t_switch output: credit-gated round-robin grant,
// registered crossbar select / VC target, and per-VC downstream credit tracking.
module t_switch_out_sched
    import common_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int CRED_W        = $clog2(VC_FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*VC_W-1:0]   req_vc,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        tx_sel,
    output logic [VC_W-1:0]         tx_vc_target,
    input  logic [VC_W-1:0]         credit_in,
    output logic [VC_W*CRED_W-1:0]  credit_cnt,
    output logic                    err
);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_FIFO_DEPTH - 1);
    localparam int                PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [CRED_W-1:0] r_cred [VC_W];
    logic [N_REQ-1:0]  r_txSel;
    logic [VC_W-1:0]   r_txVc;
    logic              r_err;

    logic [VC_W-1:0]   w_reqOh [N_REQ];
    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_multi;
    logic [N_REQ-1:0]  w_arbGnt;
    logic [VC_W-1:0]   w_credNz;
    logic [VC_W-1:0]   w_credFull;
    logic [VC_W-1:0]   w_gntVc;
    logic [PW-1:0]     w_rrPtr;
    logic              w_overflow;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            w_credNz[v]   = (r_cred[v] != '0);
            w_credFull[v] = (r_cred[v] == CRED_MAX);
        end
    end

    // Only the registered count gates eligibility; a same-cycle return does not help.
    always_comb begin
        w_elig  = '0;
        w_multi = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_reqOh[i] = VC_W'(onehot_lsb(32'(req_vc[i*VC_W +: VC_W])));
            w_multi[i] = (w_reqOh[i] != req_vc[i*VC_W +: VC_W]);
            w_elig[i]  = |(w_reqOh[i] & w_credNz);
        end
    end

    noc_rr_arb #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_elig),
        .advance (~rst),
        .gnt     (w_arbGnt),
        .ptr     (w_rrPtr)
    );

    assign gnt = rst ? '0 : w_arbGnt;

    always_comb begin
        w_gntVc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) w_gntVc = w_gntVc | w_reqOh[i];
        end
    end

    assign w_overflow = |(credit_in & ~w_gntVc & w_credFull);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++) r_cred[v] <= CRED_MAX;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                case ({w_gntVc[v], credit_in[v]})
                    2'b10:   r_cred[v] <= r_cred[v] - CRED_W'(1);
                    2'b01:   if (!w_credFull[v]) r_cred[v] <= r_cred[v] + CRED_W'(1);
                    default: r_cred[v] <= r_cred[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txSel <= '0;
            r_txVc  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_txSel <= gnt;
            r_txVc  <= w_gntVc;
            if (|w_multi || w_overflow) r_err <= 1'b1;
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int v = 0; v < VC_W; v++) credit_cnt[v*CRED_W +: CRED_W] = r_cred[v];
    end

    assign tx_sel       = r_txSel;
    assign tx_vc_target = r_txVc;
    assign err          = r_err;

    for (genvar v = 0; v < VC_W; v++) begin : g_chk
        assert property (@(posedge clk) disable iff (rst) w_gntVc[v] |-> w_credNz[v]);
    end
    assert property (@(posedge clk) disable iff (rst) int'(w_rrPtr) < N_REQ);

endmodule

// File: tb/tb_t_switch_out_sched.sv
// Scoreboard bench for t_switch_out_sched: a behavioural model predicts grants,
// credits and err; expected tx beats are queued and checked by a separate monitor.
module tb_t_switch_out_sched;

    localparam int N_REQ  = 3;
    localparam int VC_W   = 2;
    localparam int DEPTH  = 4;
    localparam int CRED_W = 2;
    localparam int MAXC   = DEPTH - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ*VC_W-1:0]  req_vc;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       tx_sel;
    logic [VC_W-1:0]        tx_vc_target;
    logic [VC_W-1:0]        credit_in;
    logic [VC_W*CRED_W-1:0] credit_cnt;
    logic                   err;

    t_switch_out_sched #(
        .N_REQ(N_REQ), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH), .CRED_W(CRED_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vc       (req_vc),
        .gnt          (gnt),
        .tx_sel       (tx_sel),
        .tx_vc_target (tx_vc_target),
        .credit_in    (credit_in),
        .credit_cnt   (credit_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [N_REQ-1:0] sel;
        logic [VC_W-1:0]  vc;
    } txExp_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     mCred [VC_W];
    int     mPtr;
    bit     mErr;
    txExp_t txQ [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int v = 0; v < VC_W; v++) mCred[v] = MAXC;
        mPtr = 0;
        mErr = 1'b0;
    endtask

    // One clock of stimulus: drive at negedge, check against the model, then let the edge happen.
    task automatic applyStimulus(input logic [N_REQ*VC_W-1:0] rq, input logic [VC_W-1:0] ci, input bit r);
        int          reqVc [N_REQ];
        int          win;
        int          k;
        int          g;
        logic [31:0] expGnt;
        logic [31:0] expCred;
        txExp_t      e;
        @(negedge clk);
        req_vc    = rq;
        credit_in = ci;
        rst       = r;
        #1;
        win = -1;
        for (int i = 0; i < N_REQ; i++) begin
            reqVc[i] = -1;
            for (int v = VC_W - 1; v >= 0; v--) if (rq[i*VC_W + v]) reqVc[i] = v;
        end
        if (!r) begin
            for (int o = 0; o < N_REQ; o++) begin
                k = (mPtr + o) % N_REQ;
                if (win < 0 && reqVc[k] >= 0 && mCred[reqVc[k]] > 0) win = k;
            end
        end
        expGnt  = (win >= 0) ? (32'd1 << win) : 32'd0;
        expCred = '0;
        for (int v = 0; v < VC_W; v++) expCred = expCred | (32'(mCred[v]) << (v * CRED_W));
        checkOutput("gnt", 32'(gnt), expGnt);
        checkOutput("credit_cnt", 32'(credit_cnt), expCred);
        checkOutput("err", 32'(err), 32'(mErr));
        if (win >= 0) begin
            e.due = cyc + 1;
            e.sel = N_REQ'(expGnt);
            e.vc  = VC_W'(32'd1 << reqVc[win]);
            txQ.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            modelReset();
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if ($countones(rq[i*VC_W +: VC_W]) > 1) mErr = 1'b1;
            for (int v = 0; v < VC_W; v++) begin
                g = (win >= 0 && reqVc[win] == v) ? 1 : 0;
                if (ci[v] && g == 0 && mCred[v] == MAXC) mErr = 1'b1;
                else mCred[v] = mCred[v] - g + int'(ci[v]);
            end
            if (win >= 0) mPtr = (win + 1) % N_REQ;
        end
    endtask

    // Monitor: each forwarded flit must match the queued prediction due this cycle.
    initial begin : monitor
        txExp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (txQ.size() != 0 && txQ[0].due == cyc) begin
                e = txQ.pop_front();
                checkOutput("tx_sel", 32'(tx_sel), 32'(e.sel));
                checkOutput("tx_vc_target", 32'(tx_vc_target), 32'(e.vc));
            end else if (tx_sel !== '0 || tx_vc_target !== '0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_spurious: got sel=%0h vc=%0h expected 0 (cycle %0d)", tx_sel, tx_vc_target, cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [N_REQ*VC_W-1:0] randReq();
        logic [N_REQ*VC_W-1:0] rq;
        int                    p;
        rq = '0;
        for (int i = 0; i < N_REQ; i++) begin
            p = $urandom_range(0, 15);
            if (p >= 15)      rq[i*VC_W +: VC_W] = 2'b11;
            else if (p >= 10) rq[i*VC_W +: VC_W] = 2'b10;
            else if (p >= 5)  rq[i*VC_W +: VC_W] = 2'b01;
        end
        return rq;
    endfunction

    initial begin : stimulus
        logic [VC_W-1:0] ci;
        rst       = 1'b1;
        req_vc    = '0;
        credit_in = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("tx_sel_reset", 32'(tx_sel), 32'd0);
        checkOutput("tx_vc_reset", 32'(tx_vc_target), 32'd0);

        $display("[TB] reset state and round-robin drain of VC0");
        applyStimulus(6'b00_00_00, 2'b00, 1'b0);
        repeat (4) applyStimulus(6'b01_01_01, 2'b00, 1'b0);

        $display("[TB] VC0 blocked, VC1 proceeds, credit return unblocks");
        applyStimulus(6'b00_10_01, 2'b00, 1'b0);
        applyStimulus(6'b00_00_01, 2'b01, 1'b0);
        applyStimulus(6'b00_00_01, 2'b00, 1'b0);

        $display("[TB] simultaneous grant and return on VC1");
        applyStimulus(6'b10_00_00, 2'b10, 1'b0);
        applyStimulus(6'b00_00_00, 2'b00, 1'b0);

        $display("[TB] credit overflow sets sticky err");
        repeat (4) applyStimulus(6'b00_00_00, 2'b01, 1'b0);
        repeat (3) applyStimulus(6'b00_00_00, 2'b00, 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus(6'b10_10_10, 2'b00, 1'b0);
        applyStimulus(6'b10_10_10, 2'b00, 1'b1);
        applyStimulus(6'b01_01_01, 2'b00, 1'b0);
        applyStimulus(6'b00_00_00, 2'b00, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            ci = '0;
            for (int v = 0; v < VC_W; v++)
                if ($urandom_range(0, 2) == 0 && (mCred[v] < MAXC || $urandom_range(0, 9) == 0)) ci[v] = 1'b1;
            applyStimulus(randReq(), ci, ($urandom_range(0, 59) == 0));
        end

        repeat (2) applyStimulus(6'b00_00_00, 2'b00, 1'b0);
        checkOutput("txq_drained", 32'(txQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
